// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants and the packet generator state type.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 8;
  localparam int unsigned AXIS_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/axis_beat_counter.sv
// Loadable down-counter of remaining beats with a registered "one beat left" flag.
module axis_beat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  // Next count; the last flag is computed ahead so it comes straight from a flop.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      last_d = (load_val_i == WIDTH'(1));
    end else if (dec_i) begin
      cnt_d  = cnt_q - WIDTH'(1);
      last_d = (cnt_q == WIDTH'(2));
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream source of fixed-length incrementing-data packets.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = AXIS_LEN_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  pkt_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  load, dec, last, hs;

  assign hs = valid_q & m_axis_tready;

  axis_beat_counter #(.WIDTH(LEN_WIDTH)) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (pkt_len),
    .dec_i      (dec),
    .last_o     (last)
  );

  // Next-state and next-output logic; every output is computed one cycle ahead
  // so the ports come directly from flops.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d = ST_SEND;
          data_d  = seed;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          data_d = data_q + DATA_WIDTH'(1);
          dec    = 1'b1;
          if (last) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: packet-level queue model plus literal checks.
module tb_axis_pkt_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pkt_len;
  logic [7:0] seed;
  logic       tready;

  logic        busy, done, tvalid, tlast;
  logic [15:0] pkt_count;
  logic [7:0]  tdata;
  logic        busy2, done2, tvalid2, tlast2;
  logic [1:0]  pkt_count2;
  logic [7:0]  tdata2;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  bit          cmp_en = 1'b0;

  always #5 clk = ~clk;

  axis_pkt_gen u_dut (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .seed(seed),
    .busy(busy), .done(done), .pkt_count(pkt_count),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast)
  );

  axis_pkt_gen #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .seed(seed),
    .busy(busy2), .done(done2), .pkt_count(pkt_count2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready),
    .m_axis_tlast(tlast2)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: an accepted start expands into its full list of beats.
  typedef struct { logic [7:0] d; logic l; } beat_t;
  beat_t       mq[$];
  bit          m_done = 1'b0;
  int unsigned m_count = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_done  = 1'b0;
      m_count = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() > 0) begin
      if (tready) begin
        if (mq[0].l) begin
          m_done = 1'b1;
          m_count++;
        end
        void'(mq.pop_front());
      end
    end else if (start && pkt_len != 0) begin
      for (int i = 0; i < int'(pkt_len); i++) begin
        beat_t b;
        b.d = 8'(int'(seed) + i);
        b.l = (i == int'(pkt_len) - 1);
        mq.push_back(b);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tvalid", tvalid, mq.size() > 0);
      chk("tvalid_c2", tvalid2, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("tdata", tdata, mq[0].d);
        chk("tlast", tlast, mq[0].l);
      end
      chk("done", done, m_done);
      chk("busy", busy, (mq.size() > 0) || m_done);
      chk("pkt_count", pkt_count, m_count % 65536);
      chk("pkt_count_c2", pkt_count2, m_count % 4);
    end
  end

  // Log of accepted beats, {tlast, tdata}, for literal checks.
  int acc[$];
  always @(posedge clk) begin
    if (!reset && tvalid && tready)
      acc.push_back({23'd0, tlast, tdata});
  end

  task automatic chk_acc(input string name, input int exp[$]);
    chk({name, "_nbeats"}, acc.size(), exp.size());
    for (int i = 0; i < exp.size() && i < acc.size(); i++)
      chk(name, acc[i], exp[i]);
  endtask

  task automatic send(input logic [7:0] len, input logic [7:0] sd,
                      input logic [7:0] pat, input int npat, input bit midstart);
    bit got = 1'b0;
    acc.delete();
    @(negedge clk);
    start = 1'b1; pkt_len = len; seed = sd;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tready = (i < npat) ? pat[i] : 1'b1;
      if (midstart && i == 1) begin
        start = 1'b1; pkt_len = 8'd5; seed = 8'h77;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start  = 1'b0;
    tready = 1'b1;
    chk("done_seen", int'(got), 1);
  endtask

  int cnt2_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; start = 1'b0; pkt_len = '0; seed = '0; tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", pkt_count, 0);
    reset = 1'b0;
    cmp_en = 1'b1;

    send(8'd4, 8'h10, 8'h00, 0, 1'b0);
    chk_acc("basic", '{'h010, 'h011, 'h012, 'h113});
    chk("basic_count", pkt_count, 1);

    send(8'd3, 8'hA0, 8'b0010_1001, 6, 1'b0);
    chk_acc("bp", '{'h0A0, 'h0A1, 'h1A2});

    send(8'd4, 8'hFE, 8'h00, 0, 1'b0);
    chk_acc("wrap", '{'h0FE, 'h0FF, 'h000, 'h101});
    send(8'd1, 8'h55, 8'h00, 0, 1'b0);
    chk_acc("single", '{'h155});
    chk("count4", pkt_count, 4);

    @(negedge clk);
    start = 1'b1; pkt_len = 8'd0; seed = 8'h99;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("zero_len_tvalid", tvalid, 0);
    end
    chk("zero_len_count", pkt_count, 4);

    send(8'd4, 8'h40, 8'h00, 0, 1'b1);
    chk_acc("midstart", '{'h040, 'h041, 'h042, 'h143});
    repeat (6) begin
      @(negedge clk);
      chk("no_second_pkt", tvalid, 0);
    end
    chk("count5", pkt_count, 5);

    acc.delete();
    @(negedge clk);
    start = 1'b1; pkt_len = 8'd8; seed = 8'h30;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_tvalid", tvalid, 0);
    chk("rstmid_tlast", tlast, 0);
    chk("rstmid_count", pkt_count, 0);
    chk("rstmid_busy", busy, 0);
    chk_acc("rstmid", '{'h030, 'h031, 'h032});

    for (int k = 0; k < 5; k++) begin
      send(8'd2, 8'h00, 8'h00, 0, 1'b0);
      if (k == 0) chk_acc("after_rst", '{'h000, 'h101});
      chk("cnt16_seq", pkt_count, k + 1);
      chk("cnt2_seq", pkt_count2, cnt2_exp[k]);
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
